rs544_522_lal8_pipe_restruct: RTL and testbench
===============================================

// Module: rs544_522_lal8_pipe_restruct
// PURPOSE
//  - RS(544,522) systematic encoder parity engine over GF(2^10), 8-symbol look-ahead LFSR.
//  - Absorbs 8 message symbols per valid beat; emits the 22 parity symbols after the last beat.
//  - Sits behind the framing logic, which front-pads 6 zero symbols so 522+6 = 66 full beats.
//  - Per-symbol step is submodule rs_lfsr22_step_const; 8 instances are chained per beat.
// PARAMETERS
//  - W            10         symbol width; field GF(2^10), primitive poly x^10+x^3+1.
//  - R            22         parity symbols = degree of g(x).
//  - L            8          symbols absorbed per beat.
//  - TAP0..TAP21  807,280,944,621,3,177,365,657,813,1010,712,466,374,544,374,482,555,976,452,899,783,513
//                 g(x) = x^22 + sum TAPi*x^i (monic).
// PORTS
//  - clk_i           in   1       clock, rising edge.
//  - rst_i           in   1       asynchronous reset, active-high.
//  - start_i         in   1       first beat of a frame (qualified by valid_i).
//  - valid_i         in   1       s_blk_i holds 8 valid symbols this cycle.
//  - last_i          in   1       final beat of frame (qualified by valid_i).
//  - s_blk_i[0:L-1]  in   L x W   beat symbols; [0] earliest, i.e. highest message degree.
//  - parity_valid_o  out  1       one-cycle pulse: parity_o updated.
//  - parity_o[0:R-1] out  R x W   parity; parity_o[i] = coefficient of x^i.
// BEHAVIOUR
//  - Step (rs_lfsr22_step_const, combinational): fb = s_in ^ rem[21];
//    rem_out[0] = fb*TAP0; rem_out[i] = rem[i-1] ^ fb*TAPi (i=1..21). GF const multiply, XOR add.
//  - Beat: chain 8 steps, lane 0 first; input state = 0 if start_i else state register.
//  - valid_i=1: state <= 8-step result. valid_i=0: state, outputs hold; start_i/last_i ignored.
//  - valid_i & last_i: parity_o <= 8-step result; parity_valid_o=1 next cycle for exactly 1 cycle.
//  - Latency: parity visible in the cycle after the last-beat edge.
//  - start_i & last_i on the same beat: legal single-beat frame from zero state.
//  - start_i mid-frame: abandons current frame, restarts from zero.
//  - Next frame's start beat may follow the last beat directly (back-to-back); parity_o holds
//    until the next last beat.
//  - Leading zero symbols do not change parity (front pad is transparent).
//  - Reset (any time, async): state, parity_o all 0, parity_valid_o=0; partial frame is discarded.
//  - Codeword = message symbols then parity_o[21]..parity_o[0]; divisible by g(x).
// CONFIGURATION
//  - RS_OUT_REG_EN defined: extra register stage on parity_o/parity_valid_o;
//    latency +1 cycle (valid 2 cycles after last-beat edge), same values.
//  - Undefined: latency as above, 1 cycle after last-beat edge.
// TESTING
//  - All-zero 522-symbol frame (66 beats, 6 zero pad) -> parity_o all 0, one valid pulse.
//  - Only data_k[0]=1 (last lane of last beat) -> parity_o[i]=TAPi (parity_o[0]=807, [21]=513).
//  - 3 random frames -> serial LFSR over 544-symbol codeword leaves remainder 0.
//  - Same frame with valid_i gaps of 1-3 cycles between beats -> identical parity.
//  - Assert rst_i at beat 30 -> outputs 0 at once; next full frame gives correct parity.
//  - Back-to-back frames, start beat right after last beat -> both parities correct, 2 pulses.

Source files
------------

// File: rtl/rs544_522_lal8_pipe_restruct.sv
// ---------------------------------------------------------------------------
// rs544_522_lal8_pipe_restruct
//
// RS(544,522) systematic encoder parity engine over GF(2^10)
// (primitive polynomial x^10 + x^3 + 1). A look-ahead LFSR absorbs eight
// message symbols per valid beat by chaining eight single-symbol division
// steps (rs_lfsr22_step_const). After the last beat of a frame the 22-symbol
// remainder is presented on parity_o with a one-cycle parity_valid_o pulse.
// The upstream framer front-pads 6 zero symbols, so a 522-symbol message
// arrives as exactly 66 full beats; leading zeros leave the remainder intact.
//
// Ports (top):
//   clk_i           clock, rising edge
//   rst_i           asynchronous reset, active-high
//   start_i         first beat of a frame (qualified by valid_i)
//   valid_i         s_blk_i carries 8 symbols this cycle
//   last_i          final beat of a frame (qualified by valid_i)
//   s_blk_i[0:L-1]  beat symbols, [0] earliest (highest message degree)
//   parity_valid_o  one-cycle pulse when parity_o has been updated
//   parity_o[0:R-1] parity, parity_o[i] = coefficient of x^i
//
// Configuration macro:
//   RS_OUT_REG_EN   adds one output register stage on parity_o and
//                   parity_valid_o (pulse 2 cycles after the last-beat edge
//                   instead of 1); values are unchanged.
//
// W, R and L are fixed by the field, the generator polynomial and the
// 8-lane datapath; they are parameters only to size the ports.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// rs_lfsr22_step_const
//
// One combinational division step by the monic generator
// g(x) = x^22 + sum TAP[i] x^i.
//   s_in     incoming message symbol
//   rem      remainder before the step, rem[i] = coefficient of x^i
//   rem_out  remainder after the step
// ---------------------------------------------------------------------------
module rs_lfsr22_step_const (
    input  logic [9:0]        s_in,
    input  logic [21:0][9:0]  rem,
    output logic [21:0][9:0]  rem_out
);

    localparam logic [9:0] TAP [0:21] = '{
        10'd807, 10'd280, 10'd944, 10'd621, 10'd3,   10'd177, 10'd365, 10'd657,
        10'd813, 10'd1010, 10'd712, 10'd466, 10'd374, 10'd544, 10'd374, 10'd482,
        10'd555, 10'd976, 10'd452, 10'd899, 10'd783, 10'd513
    };

    // Shift-and-add multiply modulo x^10 + x^3 + 1. With b a constant this
    // collapses to an XOR network of a.
    function automatic logic [9:0] gf_mul(input logic [9:0] a, input logic [9:0] b);
        logic [9:0] p;
        p = '0;
        for (int i = 9; i >= 0; i--) begin
            p = {p[8:0], 1'b0} ^ (p[9] ? 10'h009 : 10'h000);
            if (b[i]) begin
                p = p ^ a;
            end
        end
        return p;
    endfunction

    logic [9:0] fb;

    always_comb begin
        fb         = s_in ^ rem[21];
        rem_out[0] = gf_mul(fb, TAP[0]);
        for (int i = 1; i < 22; i++) begin
            rem_out[i] = rem[i-1] ^ gf_mul(fb, TAP[i]);
        end
    end

endmodule

module rs544_522_lal8_pipe_restruct #(
    parameter int unsigned W = 10,
    parameter int unsigned R = 22,
    parameter int unsigned L = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic         valid_i,
    input  logic         last_i,
    input  logic [W-1:0] s_blk_i [0:L-1],
    output logic         parity_valid_o,
    output logic [W-1:0] parity_o [0:R-1]
);

    // Remainder entering and leaving each lane. Kept as separate signals so
    // the chain has no self-referencing array.
    logic [R-1:0][W-1:0] rem_l0;
    logic [R-1:0][W-1:0] rem_l1;
    logic [R-1:0][W-1:0] rem_l2;
    logic [R-1:0][W-1:0] rem_l3;
    logic [R-1:0][W-1:0] rem_l4;
    logic [R-1:0][W-1:0] rem_l5;
    logic [R-1:0][W-1:0] rem_l6;
    logic [R-1:0][W-1:0] rem_l7;
    logic [R-1:0][W-1:0] rem_l8;

    logic [R-1:0][W-1:0] state_q;
    logic [R-1:0][W-1:0] parity_q;
    logic                parity_valid_q;

    // A start beat seeds the chain from zero, which also abandons any frame
    // still in progress.
    assign rem_l0 = start_i ? '0 : state_q;

    rs_lfsr22_step_const u_step0 (.s_in(s_blk_i[0]), .rem(rem_l0), .rem_out(rem_l1));
    rs_lfsr22_step_const u_step1 (.s_in(s_blk_i[1]), .rem(rem_l1), .rem_out(rem_l2));
    rs_lfsr22_step_const u_step2 (.s_in(s_blk_i[2]), .rem(rem_l2), .rem_out(rem_l3));
    rs_lfsr22_step_const u_step3 (.s_in(s_blk_i[3]), .rem(rem_l3), .rem_out(rem_l4));
    rs_lfsr22_step_const u_step4 (.s_in(s_blk_i[4]), .rem(rem_l4), .rem_out(rem_l5));
    rs_lfsr22_step_const u_step5 (.s_in(s_blk_i[5]), .rem(rem_l5), .rem_out(rem_l6));
    rs_lfsr22_step_const u_step6 (.s_in(s_blk_i[6]), .rem(rem_l6), .rem_out(rem_l7));
    rs_lfsr22_step_const u_step7 (.s_in(s_blk_i[7]), .rem(rem_l7), .rem_out(rem_l8));

    // Beats with valid_i low are ignored entirely, including start_i/last_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= '0;
            parity_q       <= '0;
            parity_valid_q <= 1'b0;
        end else begin
            parity_valid_q <= valid_i & last_i;
            if (valid_i) begin
                state_q <= rem_l8;
            end
            if (valid_i && last_i) begin
                parity_q <= rem_l8;
            end
        end
    end

    logic [R-1:0][W-1:0] parity_out;
    logic                parity_valid_out;

`ifdef RS_OUT_REG_EN
    logic [R-1:0][W-1:0] parity_oq;
    logic                parity_valid_oq;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            parity_oq       <= '0;
            parity_valid_oq <= 1'b0;
        end else begin
            parity_oq       <= parity_q;
            parity_valid_oq <= parity_valid_q;
        end
    end

    assign parity_out       = parity_oq;
    assign parity_valid_out = parity_valid_oq;
`else
    assign parity_out       = parity_q;
    assign parity_valid_out = parity_valid_q;
`endif

    assign parity_valid_o = parity_valid_out;

    for (genvar i = 0; i < R; i++) begin : g_par
        assign parity_o[i] = parity_out[i];
    end

endmodule

// File: tb/tb_rs544_522_lal8_pipe_restruct.sv
module tb_rs544_522_lal8_pipe_restruct;

    typedef logic [9:0]   sym_t;
    typedef logic [219:0] vec_t;

`ifdef RS_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam int TAPV [0:21] = '{
        807, 280, 944, 621, 3, 177, 365, 657, 813, 1010, 712, 466,
        374, 544, 374, 482, 555, 976, 452, 899, 783, 513
    };

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start, valid, last;
    sym_t s_blk [0:7];
    logic pv;
    sym_t parity [0:21];

    rs544_522_lal8_pipe_restruct dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .valid_i        (valid),
        .last_i         (last),
        .s_blk_i        (s_blk),
        .parity_valid_o (pv),
        .parity_o       (parity)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   gf_exp [0:1022];
    int   gf_log [0:1023];
    vec_t par_flat;
    vec_t last_got;
    vec_t cap_q [$];
    int   pcyc_q [$];
    int   ecyc_q [$];

    always_comb begin
        par_flat = '0;
        for (int i = 0; i < 22; i++) par_flat[10*i +: 10] = parity[i];
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pv === 1'b1) begin
            cap_q.push_back(par_flat);
            pcyc_q.push_back(cyc);
        end
    end

    task automatic check_val(input string tag, input vec_t got, input vec_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int gf_mul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return gf_exp[(gf_log[a] + gf_log[b]) % 1023];
    endfunction

    function automatic int gcoef(input int d);
        return (d == 22) ? 1 : TAPV[d];
    endfunction

    // Remainder of p(x) mod g(x) by polynomial long division; p is listed
    // highest degree first.
    function automatic vec_t mod_g(input sym_t p [$]);
        int   c [$];
        int   n;
        int   q;
        vec_t r;
        foreach (p[j]) c.push_back(int'(p[j]));
        n = c.size();
        for (int j = 0; j <= n - 23; j++) begin
            q = c[j];
            if (q != 0) begin
                for (int k = 0; k <= 22; k++) c[j+k] = c[j+k] ^ gf_mul(q, gcoef(22 - k));
            end
        end
        r = '0;
        for (int i = 0; i < 22; i++) r[10*i +: 10] = sym_t'(c[n-1-i]);
        return r;
    endfunction

    function automatic vec_t expect_parity(input sym_t msg [$]);
        sym_t p [$];
        p = msg;
        for (int i = 0; i < 22; i++) p.push_back('0);
        return mod_g(p);
    endfunction

    task automatic rand_msg(input int nsym, input int npad, output sym_t msg [$]);
        msg.delete();
        for (int i = 0; i < npad; i++) msg.push_back('0);
        for (int i = npad; i < nsym; i++) msg.push_back(sym_t'($urandom_range(1023, 0)));
    endtask

    task automatic send_frame(input sym_t msg [$], input int gap_max, input bit use_start,
                              input bit with_last, input bit tail, input int abort_at);
        int nb;
        int g;
        nb = msg.size() / 8;
        for (int b = 0; b < nb; b++) begin
            if (gap_max > 0) begin
                g = $urandom_range(gap_max, 1);
                repeat (g) begin
                    @(posedge clk); #1;
                    valid = 1'b0;
                    start = 1'($urandom);
                    last  = 1'($urandom);
                    for (int l = 0; l < 8; l++) s_blk[l] = sym_t'($urandom);
                end
            end
            @(posedge clk); #1;
            if (b == abort_at) begin
                #2 rst = 1'b1;
                #1;
                check_val("rst_parity", par_flat, '0);
                check_val("rst_valid", vec_t'(pv), '0);
                valid = 1'b0;
                start = 1'b0;
                last  = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            valid = 1'b1;
            start = use_start && (b == 0);
            last  = with_last && (b == nb - 1);
            for (int l = 0; l < 8; l++) s_blk[l] = msg[8*b + l];
            if (last) ecyc_q.push_back(cyc + LAT);
        end
        if (tail) begin
            @(posedge clk); #1;
            valid = 1'b0;
            start = 1'b0;
            last  = 1'b0;
        end
    endtask

    // Waits a bounded time, then checks pulse count, latency and parity values.
    task automatic expect_frames(input string tag, input vec_t exp [$]);
        int n;
        repeat (LAT + 6) @(negedge clk);
        check_val({tag, "_npulse"}, vec_t'(cap_q.size()), vec_t'(exp.size()));
        n = (cap_q.size() < exp.size()) ? cap_q.size() : exp.size();
        for (int i = 0; i < n; i++) begin
            last_got = cap_q[i];
            check_val({tag, "_parity"}, cap_q[i], exp[i]);
            if (i < ecyc_q.size() && i < pcyc_q.size())
                check_val({tag, "_latency"}, vec_t'(pcyc_q[i]), vec_t'(ecyc_q[i]));
        end
        cap_q.delete();
        pcyc_q.delete();
        ecyc_q.delete();
    endtask

    initial begin
        sym_t msg [$];
        sym_t msg_b [$];
        sym_t keep [$];
        sym_t cw [$];
        vec_t eq [$];
        vec_t tapvec;
        vec_t exp_b;
        int   e;

        e = 1;
        for (int i = 0; i < 1023; i++) begin
            gf_exp[i] = e;
            gf_log[e] = i;
            e = e << 1;
            if ((e & 'h400) != 0) e = e ^ 'h409;
        end
        tapvec = '0;
        for (int i = 0; i < 22; i++) tapvec[10*i +: 10] = sym_t'(TAPV[i]);

        valid = 1'b0;
        start = 1'b0;
        last  = 1'b0;
        for (int l = 0; l < 8; l++) s_blk[l] = '0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_val("reset_parity", par_flat, '0);
        check_val("reset_valid", vec_t'(pv), '0);
        rst = 1'b0;

        // All-zero padded frame
        msg.delete();
        for (int i = 0; i < 528; i++) msg.push_back('0);
        eq.delete(); eq.push_back('0);
        send_frame(msg, 0, 1'b1, 1'b1, 1'b1, -1);
        expect_frames("zero", eq);

        // Single 1 in the lowest message degree -> x^22 mod g = taps
        msg[527] = 10'd1;
        eq.delete(); eq.push_back(tapvec);
        send_frame(msg, 0, 1'b1, 1'b1, 1'b1, -1);
        expect_frames("unit", eq);

        // Random frames, model parity plus codeword divisibility
        for (int f = 0; f < 3; f++) begin
            rand_msg(528, 6, msg);
            keep = msg;
            eq.delete(); eq.push_back(expect_parity(msg));
            send_frame(msg, 0, 1'b1, 1'b1, 1'b1, -1);
            expect_frames("rand", eq);
            cw = msg;
            for (int i = 21; i >= 0; i--) cw.push_back(last_got[10*i +: 10]);
            check_val("cw_rem", mod_g(cw), '0);
        end

        // Same frame with idle gaps between beats
        eq.delete(); eq.push_back(expect_parity(keep));
        send_frame(keep, 3, 1'b1, 1'b1, 1'b1, -1);
        expect_frames("gaps", eq);

        // Single-beat frame: start and last together
        rand_msg(8, 0, msg);
        eq.delete(); eq.push_back(expect_parity(msg));
        send_frame(msg, 0, 1'b1, 1'b1, 1'b1, -1);
        expect_frames("onebeat", eq);

        // Abandoned partial frame followed immediately by a new start
        rand_msg(160, 0, msg_b);
        send_frame(msg_b, 0, 1'b1, 1'b0, 1'b0, -1);
        rand_msg(528, 6, msg);
        eq.delete(); eq.push_back(expect_parity(msg));
        send_frame(msg, 0, 1'b1, 1'b1, 1'b1, -1);
        expect_frames("restart", eq);

        // Reset mid-frame, then a frame relying on the reset state (no start)
        rand_msg(528, 6, msg);
        send_frame(msg, 1, 1'b1, 1'b1, 1'b1, 30);
        eq.delete();
        expect_frames("abort", eq);
        rand_msg(528, 6, msg);
        eq.delete(); eq.push_back(expect_parity(msg));
        send_frame(msg, 0, 1'b0, 1'b1, 1'b1, -1);
        expect_frames("post_rst", eq);

        // Back-to-back frames
        rand_msg(528, 6, msg);
        rand_msg(528, 6, msg_b);
        exp_b = expect_parity(msg_b);
        eq.delete(); eq.push_back(expect_parity(msg)); eq.push_back(exp_b);
        send_frame(msg, 0, 1'b1, 1'b1, 1'b0, -1);
        send_frame(msg_b, 0, 1'b1, 1'b1, 1'b1, -1);
        expect_frames("b2b", eq);
        repeat (5) @(negedge clk);
        check_val("hold_parity", par_flat, exp_b);
        check_val("hold_valid", vec_t'(pv), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
